// File: rtl/boolean_mcmc_pkg.sv
// ---------------------------------------------------------------------------
// boolean_mcmc_pkg
//
// Shared definitions for the boolean proposal path:
//   - selector_state_t : state encoding of the variable selector FSM
//   - DEFAULT_LFSR_TAPS: Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - DEFAULT_LFSR_SEED: nonzero reset / fallback seed
// ---------------------------------------------------------------------------
package boolean_mcmc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_SCAN = 2'd2
    } selector_state_t;

    localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/boolean_variable_selector_lfsr_galois.sv
// ---------------------------------------------------------------------------
// lfsr_galois
//
// Right-shifting Galois LFSR. A load of value 0 is replaced by SEED, because
// the all-zero state would lock the register up permanently.
//
// Parameters: WIDTH (state width), TAPS (feedback mask), SEED (nonzero).
// Ports:
//   clk        in   clock, rising edge
//   srst_n     in   synchronous active-low reset (state <= SEED)
//   step       in   advance one step
//   load       in   load load_value (wins over step)
//   load_value in   WIDTH  value to load; 0 means SEED
//   state      out  WIDTH  current register contents
// ---------------------------------------------------------------------------
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = (load_value == '0) ? SEED : load_value;
        end else if (step) begin
            // Bit shifted out selects whether the feedback mask is applied.
            state_next = state_reg[0] ? ((state_reg >> 1) ^ TAPS) : (state_reg >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_reg <= SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/boolean_variable_selector.sv
// ---------------------------------------------------------------------------
// boolean_variable_selector
//
// Picks one boolean variable index to flip per request. Candidates come from
// the low W bits of a Galois LFSR; frozen variables are skipped. After
// MAX_RETRIES frozen draws the request either falls back to a bounded linear
// scan (macro BOOLEAN_SELECTOR_SCAN_FALLBACK_EN defined) or reports that no
// variable is available (macro undefined).
//
// Ports:
//   in_clock                          in   clock, rising edge
//   in_reset_n                        in   synchronous active-low reset
//   in_start                          in   request; honoured only when idle
//   in_frozen_mask                    in   N  bit i set = variable i frozen
//   in_seed_load                      in   load in_seed; beats in_start
//   in_seed                           in   LFSR_WIDTH seed (0 -> LFSR_SEED)
//   out_variable_to_be_changed_index  out  W  chosen index, held
//   out_valid                         out  one-cycle result pulse
//   out_none_available                out  one-cycle "nothing found" pulse
//   out_busy                          out  high whenever not idle
//
// Requirements on parameters: LFSR_WIDTH >= W, LFSR_SEED != 0,
// MAX_RETRIES >= 1.
// ---------------------------------------------------------------------------
module boolean_variable_selector
    import boolean_mcmc_pkg::*;
#(
    parameter int                    MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX = 2,
    parameter int                    LFSR_WIDTH  = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = DEFAULT_LFSR_TAPS,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = DEFAULT_LFSR_SEED,
    parameter int                    MAX_RETRIES = 8
) (
    input  logic                                                   in_clock,
    input  logic                                                   in_reset_n,
    input  logic                                                   in_start,
    input  logic [(2**MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX)-1:0] in_frozen_mask,
    input  logic                                                   in_seed_load,
    input  logic [LFSR_WIDTH-1:0]                                  in_seed,
    output logic [MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX-1:0]    out_variable_to_be_changed_index,
    output logic                                                   out_valid,
    output logic                                                   out_none_available,
    output logic                                                   out_busy
);

    localparam int W  = MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX;
    localparam int N  = 2**W;
    localparam int RW = $clog2(MAX_RETRIES + 1);

    selector_state_t state_reg, state_next;
    logic [N-1:0]    mask_reg, mask_next;
    logic [RW-1:0]   retry_reg, retry_next;
    logic [W-1:0]    index_reg, index_next;
    logic            valid_reg, valid_next;
    logic            none_reg, none_next;

`ifdef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
    logic [W-1:0]    scan_ptr_reg, scan_ptr_next;
    logic [W-1:0]    scan_cnt_reg, scan_cnt_next;
`endif

    logic                  lfsr_step;
    logic                  lfsr_load;
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic [W-1:0]          candidate;

    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk        (in_clock),
        .srst_n     (in_reset_n),
        .step       (lfsr_step),
        .load       (lfsr_load),
        .load_value (in_seed),
        .state      (lfsr_state)
    );

    assign candidate = lfsr_state[W-1:0];

    // Only the low W LFSR bits form a candidate; the rest just carry the
    // sequence forward.
    generate
        if (LFSR_WIDTH > W) begin : g_lfsr_upper
            logic lfsr_upper_unused;
            assign lfsr_upper_unused = ^lfsr_state[LFSR_WIDTH-1:W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        retry_next = retry_reg;
        index_next = index_reg;
        valid_next = 1'b0;
        none_next  = 1'b0;
        lfsr_step  = 1'b0;
        lfsr_load  = 1'b0;
`ifdef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
        scan_ptr_next = scan_ptr_reg;
        scan_cnt_next = scan_cnt_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (in_seed_load) begin
                    // Seed load wins; a simultaneous start is dropped.
                    lfsr_load = 1'b1;
                end else if (in_start) begin
                    mask_next  = in_frozen_mask;
                    retry_next = '0;
                    lfsr_step  = 1'b1;
                    state_next = ST_DRAW;
                end
            end

            ST_DRAW: begin
`ifndef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
                // Budget spent on the previous cycle: report and give up.
                if (retry_reg == RW'(MAX_RETRIES)) begin
                    none_next  = 1'b1;
                    state_next = ST_IDLE;
                end else
`endif
                if (!mask_reg[candidate]) begin
                    index_next = candidate;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    retry_next = retry_reg + RW'(1);
                    lfsr_step  = 1'b1;
`ifdef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
                    // Last random draw was frozen: scan starting just past it.
                    if (retry_reg == RW'(MAX_RETRIES - 1)) begin
                        scan_ptr_next = candidate + W'(1);
                        scan_cnt_next = '0;
                        state_next    = ST_SCAN;
                    end
`endif
                end
            end

`ifdef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
            ST_SCAN: begin
                if (!mask_reg[scan_ptr_reg]) begin
                    index_next = scan_ptr_reg;
                    valid_next = 1'b1;
                    state_next = ST_IDLE;
                end else if (scan_cnt_reg == W'(N - 1)) begin
                    // Every position tested once: all variables frozen.
                    none_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    scan_ptr_next = scan_ptr_reg + W'(1);
                    scan_cnt_next = scan_cnt_reg + W'(1);
                end
            end
`endif

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state_reg <= ST_IDLE;
            mask_reg  <= '0;
            retry_reg <= '0;
            index_reg <= '0;
            valid_reg <= 1'b0;
            none_reg  <= 1'b0;
`ifdef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
            scan_ptr_reg <= '0;
            scan_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            retry_reg <= retry_next;
            index_reg <= index_next;
            valid_reg <= valid_next;
            none_reg  <= none_next;
`ifdef BOOLEAN_SELECTOR_SCAN_FALLBACK_EN
            scan_ptr_reg <= scan_ptr_next;
            scan_cnt_reg <= scan_cnt_next;
`endif
        end
    end

    assign out_variable_to_be_changed_index = index_reg;
    assign out_valid                        = valid_reg;
    assign out_none_available               = none_reg;
    assign out_busy                         = (state_reg != ST_IDLE);

endmodule

// File: doc/boolean_variable_selector.md
# boolean_variable_selector

Upstream stage of the boolean proposal path: on each request it picks one boolean variable index to be flipped, drawn pseudo-randomly from an internal Galois LFSR and skipping variables marked frozen. The result is the flip index plus a one-cycle valid pulse, which drive the boolean propose stage's variable-index and enable inputs directly. When the retry budget runs out, a bounded deterministic scan guarantees a result whenever any variable is unfrozen.

## Interface

Parameters:
- MAX_BIT_WIDTH_OF_BOOLEAN_VARIABLES_INDEX, 2: index width W; variable count N = 2**W.
- LFSR_WIDTH, 16: LFSR state width; must be ≥ W.
- LFSR_TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- LFSR_SEED, 16'hACE1: reset/fallback seed; must be nonzero.
- MAX_RETRIES, 8: random draws attempted before fallback; must be ≥ 1.

Ports:
- in_clock  input  1  single clock, all logic on rising edge.
- in_reset_n  input  1  synchronous, active-low reset.
- in_start  input  1  request a new index; honoured only in IDLE.
- in_frozen_mask  input  N  bit i = 1 → variable i must not be chosen; captured on accepted start.
- in_seed_load  input  1  load in_seed into LFSR; honoured only in IDLE.
- in_seed  input  LFSR_WIDTH  seed value; 0 replaced by LFSR_SEED.
- out_variable_to_be_changed_index  output  W  chosen index, held until the next result.
- out_valid  output  1  one-cycle pulse, index valid.
- out_none_available  output  1  one-cycle pulse, no selectable variable found.
- out_busy  output  1  high in every state except IDLE.

## Operation

- States: IDLE, DRAW, SCAN. The reset state is IDLE.
- IDLE:
  - in_seed_load has priority over in_start in the same cycle: the LFSR is loaded, and the start is dropped.
  - On in_start: capture the mask, clear the retry counter, advance the LFSR one step, go to DRAW.
- DRAW:
  - Candidate c = lfsr[W-1:0].
  - If mask[c] = 0: register index c, pulse out_valid, go to IDLE.
  - Otherwise increment the retry counter and advance the LFSR.
  - When the counter reaches MAX_RETRIES: go to SCAN with scan pointer = c+1 mod N and scan counter 0.
- SCAN:
  - Test the pointer position each cycle.
  - If unfrozen: register it, pulse out_valid, go to IDLE.
  - Otherwise the pointer increments with wrap (N-1 → 0).
  - After N tests with no hit: pulse out_none_available, go to IDLE.
- LFSR step:
  - If lsb = 1: lfsr = (lfsr >> 1) ^ LFSR_TAPS.
  - Else: lfsr = lfsr >> 1.
  - The LFSR advances only on the start and DRAW events above, so the sequence is reproducible from the seed.
- in_start, in_seed_load and mask changes while busy are ignored. The mask in use is the captured copy.
- out_valid and out_none_available are never high in the same cycle.

## Timing

- Reset values:
  - state = IDLE, lfsr = LFSR_SEED.
  - out_variable_to_be_changed_index = 0.
  - out_valid = 0, out_none_available = 0, out_busy = 0.
- Reset mid-search aborts the search; no pulse is issued.
- Best case: in_start sampled at edge t → out_valid high in cycle t+2.
- Each frozen random draw adds 1 cycle.
- Worst case with a hit: 2 + MAX_RETRIES + (N-1) cycles.
- All frozen: out_none_available in cycle t + 2 + MAX_RETRIES + N - 1.
- A new in_start is accepted in the same cycle out_valid is high, because the state is already IDLE.

## Configuration

- BOOLEAN_SELECTOR_SCAN_FALLBACK_EN defined: SCAN state present; behaviour as above.
- Not defined:
  - No SCAN state.
  - When retries are exhausted, pulse out_none_available in the next cycle and return to IDLE, even if unfrozen variables exist.
  - Worst-case latency becomes 2 + MAX_RETRIES.

## Structure

- Shared package boolean_mcmc_pkg holds:
  - The state enum (IDLE/DRAW/SCAN).
  - Default LFSR_TAPS and LFSR_SEED constants.
- One sub-module, lfsr_galois (parameters WIDTH, TAPS, SEED; ports step, load, load_value, state), holds the LFSR and its zero-seed substitution.

## Test plan

- Reset, then in_start with mask 4'b0000 and LFSR_SEED: index = (one step of 16'hACE1)[1:0], out_valid pulses at t+2, out_busy high during DRAW.
- Mask 4'b1111, fallback enabled: out_none_available pulses at t+2+8+3 = t+13; out_valid never asserts; state returns to IDLE.
- Mask 4'b1110, MAX_RETRIES=1: seed chosen so the first draw gives 1 → SCAN visits 2, 3, 0 (wrap) and returns index 0.
- in_seed_load with in_seed = 0, then start: identical sequence to reset seed 16'hACE1. Two runs with the same seed produce identical index streams.
- in_start pulsed and mask toggled during DRAW: extra start ignored; result follows the captured mask. Back-to-back start on the out_valid cycle is accepted.
- Fallback macro undefined, mask 4'b1111: out_none_available at t+2+MAX_RETRIES. in_reset_n low mid-DRAW: all outputs return to reset values next cycle, with no pulse.
